// File: rtl/alt_ddrx_ecc_encoder_pipe_pkg.sv
// Shared helpers for the SECDED encoder pipe: check-bit count, data-to-codeword
// index mapping and the error-injection mode encodings.
package alt_ddrx_ecc_encoder_pipe_pkg;

    typedef enum logic [1:0] {
        INJ_CLEAR = 2'b00,
        INJ_BIT0  = 2'b01,
        INJ_BIT01 = 2'b10,
        INJ_CHK0  = 2'b11
    } inject_mode_e;

    // Smallest K with 2^K >= DATA_WIDTH + K + 1 (6 for 32 bits, 7 for 64 bits).
    function automatic int ecc_check_bits(input int dw);
        int k;
        k = 1;
        while ((1 << k) < dw + k + 1)
            k = k + 1;
        return k;
    endfunction

    // Codeword index of data bit j: the j-th index that is not a power of two.
    function automatic int data_index(input int j);
        int idx;
        int n;
        idx = 2;
        n   = -1;
        while (n < j) begin
            idx = idx + 1;
            if ((idx & (idx - 1)) != 0)
                n = n + 1;
        end
        return idx;
    endfunction

    // Data bits that feed check bit i.
    function automatic logic [63:0] check_mask(input int dw, input int i);
        logic [63:0] m;
        m = '0;
        for (int j = 0; j < dw; j++)
            if (((data_index(j) >> i) & 1) != 0)
                m[j] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/alt_ddrx_ecc_secded_gen.sv
// Combinational SECDED codeword builder: {pad, parity, check bits, data};
// check and parity are forced to zero in bypass.
module alt_ddrx_ecc_secded_gen
    import alt_ddrx_ecc_encoder_pipe_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int OUTPUT_DATA_WIDTH = 72
) (
    input  logic [DATA_WIDTH-1:0]        data,
    input  logic                         ecc_enable,
    output logic [OUTPUT_DATA_WIDTH-1:0] codeword
);

    localparam int K = ecc_check_bits(DATA_WIDTH);

    logic [K-1:0] chk;

    for (genvar i = 0; i < K; i++) begin : g_chk
        localparam logic [63:0] MASK = check_mask(DATA_WIDTH, i);
        assign chk[i] = ^(data & MASK[DATA_WIDTH-1:0]);
    end

    always_comb begin
        codeword = '0;
        codeword[DATA_WIDTH-1:0] = data;
        if (ecc_enable) begin
            codeword[DATA_WIDTH +: K] = chk;
            codeword[DATA_WIDTH + K]  = ^{data, chk};
        end
    end

endmodule

// File: rtl/alt_ddrx_ecc_encoder_pipe.sv
// Valid/ready SECDED encoder pipeline (1 or 2 stages) with one-shot error
// injection and a delivered-codeword counter.
module alt_ddrx_ecc_encoder_pipe
    import alt_ddrx_ecc_encoder_pipe_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int OUTPUT_DATA_WIDTH = 72,
    parameter int PIPE_STAGES       = 2
) (
    input  logic                         ctl_clk,
    input  logic                         ctl_reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OUTPUT_DATA_WIDTH-1:0] out_data,
    input  logic                         ecc_enable,
    input  logic                         inject_req,
    input  logic [1:0]                   inject_mode,
    output logic                         inject_pending,
    output logic [15:0]                  enc_count
);

    if (!((DATA_WIDTH == 32 && OUTPUT_DATA_WIDTH == 40) ||
          (DATA_WIDTH == 64 && OUTPUT_DATA_WIDTH == 72))) begin : g_width_err
        $error("alt_ddrx_ecc_encoder_pipe: illegal DATA_WIDTH/OUTPUT_DATA_WIDTH pair");
    end
    if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_stage_err
        $error("alt_ddrx_ecc_encoder_pipe: PIPE_STAGES must be 1 or 2");
    end

    logic                         accept;
    logic                         out_adv;
    logic                         gen_load;
    logic                         gen_en;
    logic [DATA_WIDTH-1:0]        gen_data;
    logic [OUTPUT_DATA_WIDTH-1:0] gen_mask;
    logic [OUTPUT_DATA_WIDTH-1:0] codeword;
    logic [OUTPUT_DATA_WIDTH-1:0] inj_mask;
    logic                         armed;
    inject_mode_e                 armed_mode;

    assign accept         = in_valid & in_ready;
    assign out_adv        = out_ready | ~out_valid;
    assign inject_pending = armed;

    // The mask is resolved at accept so it rides with its word through the pipe.
    always_comb begin
        inj_mask = '0;
        if (armed) begin
            case (armed_mode)
                INJ_BIT0:  inj_mask[0]          = 1'b1;
                INJ_BIT01: inj_mask[1:0]        = 2'b11;
                INJ_CHK0:  inj_mask[DATA_WIDTH] = 1'b1;
                default:   inj_mask             = '0;
            endcase
        end
    end

    // A request on the accept cycle re-arms after the old mask was taken.
    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            armed      <= 1'b0;
            armed_mode <= INJ_CLEAR;
        end else if (inject_req) begin
            armed      <= (inject_mode != 2'b00);
            armed_mode <= inject_mode_e'(inject_mode);
        end else if (accept) begin
            armed      <= 1'b0;
        end
    end

    if (PIPE_STAGES == 2) begin : g_two
        logic                         s1_valid;
        logic                         s1_en;
        logic [DATA_WIDTH-1:0]        s1_data;
        logic [OUTPUT_DATA_WIDTH-1:0] s1_mask;

        assign in_ready = ~ctl_reset & (~s1_valid | out_adv);
        assign gen_load = s1_valid & out_adv;
        assign gen_data = s1_data;
        assign gen_en   = s1_en;
        assign gen_mask = s1_mask;

        always_ff @(posedge ctl_clk) begin
            if (ctl_reset) begin
                s1_valid <= 1'b0;
                s1_en    <= 1'b0;
                s1_data  <= '0;
                s1_mask  <= '0;
            end else if (accept) begin
                s1_valid <= 1'b1;
                s1_en    <= ecc_enable;
                s1_data  <= in_data;
                s1_mask  <= inj_mask;
            end else if (out_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end else begin : g_one
        assign in_ready = ~ctl_reset & out_adv;
        assign gen_load = accept;
        assign gen_data = in_data;
        assign gen_en   = ecc_enable;
        assign gen_mask = inj_mask;
    end

    alt_ddrx_ecc_secded_gen #(
        .DATA_WIDTH       (DATA_WIDTH),
        .OUTPUT_DATA_WIDTH(OUTPUT_DATA_WIDTH)
    ) u_gen (
        .data      (gen_data),
        .ecc_enable(gen_en),
        .codeword  (codeword)
    );

    always_ff @(posedge ctl_clk) begin
        if (ctl_reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            enc_count <= '0;
        end else begin
            if (gen_load) begin
                out_valid <= 1'b1;
                out_data  <= codeword ^ gen_mask;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (out_valid && out_ready)
                enc_count <= enc_count + 16'd1;
        end
    end

endmodule
